lock_controller: RTL and testbench

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_controller.sv | 202 ++++++++++++++++++++
 tb/tb_lock_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller.sv
// Four-digit push-button lock with relock timeout, code programming and
// lockout after repeated wrong entries.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_ENTRY      | collecting digits of a code attempt
// S_CHECK      | one cycle: compare captured attempt with stored code
// S_OPEN       | unlocked; waits for timeout, relock press or SET start
// S_FAIL       | one cycle: error pulse, bump fail count
// S_LOCKED_OUT | all presses ignored until the lockout timer expires
// S_SET        | unlocked; collecting a new code
module lock_controller #(
    parameter int unsigned UNLOCK_CYCLES  = 100000000,
    parameter int unsigned LOCKOUT_CYCLES = 500000000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter logic [7:0]  DEFAULT_CODE   = 8'b00_01_10_11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       set_mode,
    output logic       unlocked,
    output logic       error,
    output logic       lockout,
    output logic [2:0] digit_count
);

    localparam int unsigned TIMER_MAX =
        (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = $clog2(64'(TIMER_MAX) + 64'd1);
    localparam int FAIL_W  = (MAX_FAILS < 1) ? 1 : $clog2(MAX_FAILS + 1);

    // Timers count down from N-1 so a state holds for exactly N cycles.
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKED_OUT,
        S_SET
    } state_t;

    state_t              state, state_d;
    logic [3:0]          btn_prev;
    logic [7:0]          entry_reg, entry_d;
    logic [7:0]          code_reg, code_d;
    logic [FAIL_W-1:0]   fail_cnt, fail_d, fail_inc;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [2:0]          count_d;
    logic                error_d;

    logic [3:0] press;
    logic       press_valid;
    logic       press_multi;
    logic [1:0] press_digit;

    assign press       = btn & ~btn_prev;
    assign press_valid = $onehot(press);
    assign press_multi = (press != 4'b0000) && !press_valid;

    // Bit index of a single-bit press; only meaningful when press_valid.
    always_comb begin
        press_digit = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) press_digit = 2'(i);
        end
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_ENTRY;
            btn_prev    <= btn;
            entry_reg   <= '0;
            code_reg    <= DEFAULT_CODE;
            fail_cnt    <= '0;
            timer       <= '0;
            digit_count <= '0;
            unlocked    <= 1'b0;
            error       <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            state       <= state_d;
            btn_prev    <= btn;
            entry_reg   <= entry_d;
            code_reg    <= code_d;
            fail_cnt    <= fail_d;
            timer       <= timer_d;
            digit_count <= count_d;
            unlocked    <= (state == S_OPEN) || (state == S_SET);
            error       <= error_d;
            lockout     <= (state == S_LOCKED_OUT);
        end
    end

    // Next-state and datapath update; every path starts from hold values.
    always_comb begin
        state_d  = state;
        entry_d  = entry_reg;
        code_d   = code_reg;
        fail_d   = fail_cnt;
        timer_d  = timer;
        count_d  = digit_count;
        error_d  = 1'b0;
        fail_inc = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;

        case (state)
            S_ENTRY: begin
                if (press_multi) begin
                    error_d = 1'b1;
                    entry_d = '0;
                    count_d = '0;
                end else if (press_valid) begin
                    entry_d = {entry_reg[5:0], press_digit};
                    count_d = digit_count + 3'd1;
                    if (digit_count == 3'd3) state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                count_d = '0;
                if (entry_reg == code_reg) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                    timer_d = UNLOCK_LOAD;
                end else begin
                    state_d = S_FAIL;
                end
            end

            S_OPEN: begin
                if (press_multi) begin
                    error_d = 1'b1;
                    state_d = S_ENTRY;
                end else if (press_valid) begin
                    if (set_mode) begin
                        state_d = S_SET;
                        entry_d = {6'b0, press_digit};
                        count_d = 3'd1;
                        timer_d = UNLOCK_LOAD;
                    end else begin
                        state_d = S_ENTRY;
                    end
                end else if (timer == '0) begin
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end

            S_SET: begin
                if (press_multi) begin
                    error_d = 1'b1;
                    count_d = '0;
                    state_d = S_ENTRY;
                end else if (press_valid) begin
                    entry_d = {entry_reg[5:0], press_digit};
                    timer_d = UNLOCK_LOAD;
                    if (digit_count == 3'd3) begin
                        code_d  = {entry_reg[5:0], press_digit};
                        count_d = '0;
                        state_d = S_ENTRY;
                    end else begin
                        count_d = digit_count + 3'd1;
                    end
                end else if (timer == '0) begin
                    count_d = '0;
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end

            S_FAIL: begin
                error_d = 1'b1;
                fail_d  = fail_inc;
                if (fail_inc == FAIL_LIMIT) begin
                    state_d = S_LOCKED_OUT;
                    timer_d = LOCKOUT_LOAD;
                end else begin
                    state_d = S_ENTRY;
                end
            end

            S_LOCKED_OUT: begin
                if (timer == '0) begin
                    fail_d  = '0;
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end

            default: state_d = S_ENTRY;
        endcase
    end

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus tasks predict output
// events (time and value) from the lock's rules; a monitor compares every
// observed output change against those predictions.
module tb_lock_controller;

    localparam int UNLOCK  = 8;
    localparam int LOCKOUT = 16;
    localparam int MAXF    = 3;

    localparam int K_DC  = 0;
    localparam int K_ERR = 1;
    localparam int K_ULK = 2;
    localparam int K_LCK = 3;

    typedef struct { int cyc; int val; } ev_t;
    typedef int code_t [4];

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       set_mode;
    logic       unlocked;
    logic       error;
    logic       lockout;
    logic [2:0] digit_count;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    ev_t q_dc[$];
    ev_t q_err[$];
    ev_t q_ulk[$];
    ev_t q_lck[$];

    code_t m_code;
    int    m_fails;
    int    m_dc;

    lock_controller #(
        .UNLOCK_CYCLES (UNLOCK),
        .LOCKOUT_CYCLES(LOCKOUT),
        .MAX_FAILS     (MAXF),
        .DEFAULT_CODE  (8'b00_01_10_11)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .btn        (btn),
        .set_mode   (set_mode),
        .unlocked   (unlocked),
        .error      (error),
        .lockout    (lockout),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic push_ev(input int kind, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        case (kind)
            K_DC:    q_dc.push_back(e);
            K_ERR:   q_err.push_back(e);
            K_ULK:   q_ulk.push_back(e);
            default: q_lck.push_back(e);
        endcase
    endtask

    task automatic exp_dc(input int c, input int v);
        if (v != m_dc) push_ev(K_DC, c, v);
        m_dc = v;
    endtask

    task automatic observe(input int kind, input int v);
        ev_t   e;
        bit    got;
        string nm;
        got = 0;
        e.cyc = 0;
        e.val = 0;
        case (kind)
            K_DC:    begin nm = "digit_count"; if (q_dc.size()  > 0) begin e = q_dc.pop_front();  got = 1; end end
            K_ERR:   begin nm = "error";       if (q_err.size() > 0) begin e = q_err.pop_front(); got = 1; end end
            K_ULK:   begin nm = "unlocked";    if (q_ulk.size() > 0) begin e = q_ulk.pop_front(); got = 1; end end
            default: begin nm = "lockout";     if (q_lck.size() > 0) begin e = q_lck.pop_front(); got = 1; end end
        endcase
        n_checks++;
        if (!got) begin
            n_err++;
            $display("FAIL %s: changed to %0d at cycle %0d, no change required", nm, v, cyc);
        end else if (e.cyc != cyc || e.val != v) begin
            n_err++;
            $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                     nm, v, cyc, e.val, e.cyc);
        end
    endtask

    initial begin : monitor
        logic [2:0] p_dc;
        logic       p_ulk, p_lck;
        wait (mon_en);
        p_dc  = 3'd0;
        p_ulk = 1'b0;
        p_lck = 1'b0;
        forever begin
            @(negedge clk);
            if (digit_count != p_dc) observe(K_DC, int'(digit_count));
            if (error)               observe(K_ERR, 1);
            if (unlocked != p_ulk)   observe(K_ULK, int'(unlocked));
            if (lockout != p_lck)    observe(K_LCK, int'(lockout));
            p_dc  = digit_count;
            p_ulk = unlocked;
            p_lck = lockout;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic check_eq(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Drive one digit; e returns the edge index that captures it.
    task automatic press(input int d, input int hold, output int e);
        btn = 4'(1 << d);
        step();
        e = cyc;
        repeat (hold - 1) step();
        btn = 4'b0000;
        step();
    endtask

    task automatic set_default_code();
        m_code = '{0, 1, 2, 3};
    endtask

    task automatic do_reset(input bit ulk_high);
        reset = 1'b1;
        exp_dc(cyc + 1, 0);
        if (ulk_high) push_ev(K_ULK, cyc + 1, 0);
        step();
        reset = 1'b0;
        set_default_code();
        m_fails = 0;
    endtask

    task automatic partial(input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            exp_dc(cyc + 1, i + 1);
            press($urandom_range(0, 3), 1, e);
        end
    endtask

    task automatic invalid_press(input logic [3:0] mask);
        push_ev(K_ERR, cyc + 1, 1);
        exp_dc(cyc + 1, 0);
        btn = mask;
        step();
        btn = 4'b0000;
        step();
    endtask

    // Full 4-digit attempt; predicts unlock / error / lockout from the code.
    task automatic attempt(input code_t dg, input int hold0,
                           output int e4, output bit ok, output bit locked);
        int e, c;
        ok = 1;
        locked = 0;
        e = 0;
        for (int i = 0; i < 4; i++) if (dg[i] != m_code[i]) ok = 0;
        for (int i = 0; i < 4; i++) begin
            c = cyc + 1;
            exp_dc(c, i + 1);
            if (i == 3) begin
                exp_dc(c + 1, 0);
                if (ok) begin
                    push_ev(K_ULK, c + 2, 1);
                    m_fails = 0;
                end else begin
                    push_ev(K_ERR, c + 2, 1);
                    m_fails++;
                    if (m_fails >= MAXF) begin
                        locked = 1;
                        push_ev(K_LCK, c + 3, 1);
                        push_ev(K_LCK, c + 3 + LOCKOUT, 0);
                        m_fails = 0;
                    end
                end
            end
            press(dg[i], (i == 0) ? hold0 : 1, e);
        end
        e4 = e;
    endtask

    // plan: 0 timeout, 1 relock press, 2 program nd (nset digits),
    //       3 programming abandoned by timeout, 4 reset mid-programming
    task automatic run_attempt(input code_t dg, input int hold0, input int plan,
                               input code_t nd, input int nset);
        int e4, e, c, k;
        bit ok, locked;
        e = 0;
        attempt(dg, hold0, e4, ok, locked);
        if (!ok) begin
            if (locked) begin
                repeat (4) press($urandom_range(0, 3), 1, e);
                wait_until(e4 + 3 + LOCKOUT);
            end else begin
                wait_until(e4 + 2);
            end
        end else if (plan == 1) begin
            k = $urandom_range(0, 5);
            repeat (k) step();
            push_ev(K_ULK, cyc + 2, 0);
            press($urandom_range(0, 3), 1, e);
        end else if (plan >= 2) begin
            set_mode = 1'b1;
            for (int i = 0; i < nset; i++) begin
                c = cyc + 1;
                if (i < 3) exp_dc(c, i + 1);
                else begin
                    exp_dc(c, 0);
                    push_ev(K_ULK, c + 1, 0);
                end
                press(nd[i], 1, e);
            end
            set_mode = 1'b0;
            if (nset == 4) begin
                m_code = nd;
                step();
            end else if (plan == 3) begin
                exp_dc(e + UNLOCK, 0);
                push_ev(K_ULK, e + UNLOCK + 1, 0);
                wait_until(e + UNLOCK + 2);
            end else begin
                do_reset(1);
            end
        end else begin
            push_ev(K_ULK, e4 + 2 + UNLOCK, 0);
            wait_until(e4 + 3 + UNLOCK);
        end
    endtask

    task automatic rand_code(output code_t d);
        for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 3);
    endtask

    task automatic wrong_code(output code_t d);
        bit same;
        rand_code(d);
        same = 1;
        for (int i = 0; i < 4; i++) if (d[i] != m_code[i]) same = 0;
        if (same) d[0] = (m_code[0] + 1) % 4;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        code_t c0123, c3333, c2210, cr, nd;
        logic [3:0] mask;
        int sel;

        c0123 = '{0, 1, 2, 3};
        c3333 = '{3, 3, 3, 3};
        c2210 = '{2, 2, 1, 0};
        set_default_code();
        m_fails = 0;
        m_dc    = 0;

        reset    = 1'b1;
        btn      = 4'b0000;
        set_mode = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        check_eq("reset unlocked",    int'(unlocked),    0);
        check_eq("reset error",       int'(error),       0);
        check_eq("reset lockout",     int'(lockout),     0);
        check_eq("reset digit_count", int'(digit_count), 0);
        mon_en = 1;
        step();

        // default code unlocks; held button counts once
        run_attempt(c0123, 1, 0, c0123, 0);
        run_attempt(c0123, 10, 0, c0123, 0);

        // three wrong entries lock out, presses ignored, then unlock works
        repeat (3) run_attempt(c3333, 1, 0, c0123, 0);
        run_attempt(c0123, 1, 0, c0123, 0);

        // invalid press mid-entry leaves fail count alone
        run_attempt(c3333, 1, 0, c0123, 0);
        partial(1);
        invalid_press(4'b0011);
        run_attempt(c3333, 1, 0, c0123, 0);
        run_attempt(c3333, 1, 0, c0123, 0);

        // program 2,2,1,0; old code fails, new code unlocks
        run_attempt(c0123, 1, 2, c2210, 4);
        run_attempt(c0123, 1, 0, c0123, 0);
        run_attempt(c2210, 1, 0, c0123, 0);

        // reset mid-entry and mid-programming restores default code
        partial(2);
        do_reset(0);
        run_attempt(c0123, 1, 2, c2210, 4);
        partial(2);
        do_reset(0);
        run_attempt(c0123, 1, 4, c2210, 2);
        run_attempt(c0123, 1, 1, c0123, 0);

        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: run_attempt(m_code, ($urandom_range(0, 1) == 1) ? 10 : 1, 0, m_code, 0);
                1: begin wrong_code(cr); run_attempt(cr, 1, 0, m_code, 0); end
                2: begin rand_code(cr); run_attempt(cr, 1, 1, m_code, 0); end
                3: run_attempt(m_code, 1, 1, m_code, 0);
                4: begin rand_code(nd); run_attempt(m_code, 1, 2, nd, 4); end
                5: begin
                    partial($urandom_range(0, 3));
                    do mask = 4'($urandom_range(0, 15)); while ($countones(mask) < 2);
                    invalid_press(mask);
                end
                6: begin rand_code(nd); run_attempt(m_code, 1, 3, nd, $urandom_range(1, 3)); end
                default: begin partial($urandom_range(1, 3)); do_reset(0); end
            endcase
        end

        repeat (5) step();
        check_eq("pending digit_count events", q_dc.size(),  0);
        check_eq("pending error events",       q_err.size(), 0);
        check_eq("pending unlocked events",    q_ulk.size(), 0);
        check_eq("pending lockout events",     q_lck.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
